ofs_fim_hssi_tx_axis_arb: RTL
=============================

Name: ofs_fim_hssi_tx_axis_arb

Overview:
- Packet-atomic round-robin multiplexer that merges NUM_CH client HSSI TX AXI-S streams into one MAC-side TX stream.
- Sits between the HE-HSSI/AFU TX ports and a single HSSI SS TX channel.
- Tags each outgoing beat with the source channel ID.
- Honours the MAC flow-control tx_pause at packet boundaries.
- Parametrised successor of the single-stream TX AXI-S channel, generalised in channel count and widths.

Parameters:
- NUM_CH, 4, number of client TX streams (1..16).
- DATA_W, 64, tdata width in bits (multiple of 8).
- USER_W, 2, tuser width per beat.
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of channel ID; derived, do not override.

Ports:
- clk  input  1  stream clock, common to all channels (MAC clock).
- rst_n  input  1  reset; asynchronous assert, active-low.
- s_tvalid  input  NUM_CH  per-channel tvalid.
- s_tready  output  NUM_CH  per-channel tready.
- s_tdata  input  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- s_tkeep  input  NUM_CH*DATA_W/8  per-channel byte enables.
- s_tlast  input  NUM_CH  per-channel end of packet.
- s_tuser  input  NUM_CH*USER_W  per-channel sideband.
- m_tvalid  output  1  MAC-side tvalid.
- m_tready  input  1  MAC-side tready.
- m_tdata  output  DATA_W  merged data.
- m_tkeep  output  DATA_W/8  merged byte enables.
- m_tlast  output  1  merged end of packet.
- m_tuser  output  USER_W  merged sideband.
- m_tid  output  CH_W  source channel of the current beat.
- tx_pause  input  1  MAC flow-control pause, level-sensitive.
- busy  output  1  high while a packet is locked.
- pkt_done  output  1  one-cycle pulse when a tlast beat is accepted from a client.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; m_tvalid=0; s_tready=0; busy=0; pkt_done=0.
  - m_tdata/m_tkeep/m_tlast/m_tuser/m_tid=0.
  - last_grant=NUM_CH-1, so channel 0 has first priority after reset.
- FSM has two states: IDLE and LOCK.
- IDLE:
  - If tx_pause=0 and any s_tvalid is high, choose the first channel with s_tvalid=1, searching (last_grant+1) mod NUM_CH upward with wrap.
  - Register the choice as sel and go to LOCK next cycle.
  - If tx_pause=1, no grant is made; stay in IDLE.
- LOCK:
  - s_tready[sel] = (~m_tvalid | m_tready). This is a combinational path from m_tready.
  - All other s_tready bits are 0.
  - On an accepted beat, the output register loads that channel's data/keep/last/user, m_tid=sel, m_tvalid=1.
  - On an accepted beat with s_tlast=1: pkt_done=1 for one cycle, last_grant=sel, state goes to IDLE.
  - tx_pause is ignored mid-packet; the packet always completes.
- Output register:
  - m_tvalid clears when m_tready=1 and no new beat is accepted in the same cycle.
  - While m_tvalid=1 and m_tready=0, all m_* outputs hold stable.
- Throughput and latency:
  - 1 beat/cycle within a packet.
  - Exactly one idle arbitration cycle between packets on the input side.
  - Input-to-output latency is 1 cycle.
- Beats from a non-granted channel are never consumed; its tvalid may stay high indefinitely.
- Arbitration is fair: a continuously requesting channel waits at most NUM_CH-1 packets.
- NUM_CH=1: sel is always 0 and m_tid=0; the FSM behaviour is unchanged.
- A tvalid drop mid-packet on the granted channel stalls the output (m_tvalid deasserts after draining) while staying in LOCK.
- busy = (state==LOCK).

Test Plan:
- Reset release, all s_tvalid=0 for 10 cycles -> m_tvalid=0, s_tready=0, busy=0 throughout.
- Channels 0..3 each send one 3-beat packet simultaneously -> output order ch0,ch1,ch2,ch3. m_tid constant within each packet; 12 beats total; each packet's m_tlast on its 3rd beat; 4 pkt_done pulses.
- ch2 sends continuously with m_tready=1 -> ch2 packets back-to-back with 1 bubble cycle each. Then ch0 requests -> ch0 is granted after ch2's current packet completes, then ch2 resumes.
- tx_pause=1 asserted on beat 2 of a 5-beat ch1 packet -> all 5 beats delivered. No new grant while pause=1. Grant occurs the cycle after pause drops.
- m_tready toggles 1,0,0,1 during a packet with data 0xA5A5..0001 -> m_* holds stable while m_tready=0; no beat lost or duplicated.
- rst_n asserted mid-packet on ch3 -> outputs go to 0 immediately. After release, ch0 wins when ch0 and ch3 both request.

Source files
------------

// File: rtl/ofs_fim_hssi_tx_axis_arb_if.sv
// Bundle of the client-side and MAC-side TX AXI-S signals around the TX arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface ofs_fim_hssi_tx_axis_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int USER_W = 2,
    parameter int CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
);
    logic [NUM_CH-1:0]          s_tvalid;
    logic [NUM_CH-1:0]          s_tready;
    logic [NUM_CH*DATA_W-1:0]   s_tdata;
    logic [NUM_CH*DATA_W/8-1:0] s_tkeep;
    logic [NUM_CH-1:0]          s_tlast;
    logic [NUM_CH*USER_W-1:0]   s_tuser;

    logic                       m_tvalid;
    logic                       m_tready;
    logic [DATA_W-1:0]          m_tdata;
    logic [DATA_W/8-1:0]        m_tkeep;
    logic                       m_tlast;
    logic [USER_W-1:0]          m_tuser;
    logic [CH_W-1:0]            m_tid;

    modport master (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid
    );

    modport slave (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid
    );
endinterface

// File: rtl/ofs_fim_hssi_tx_axis_arb.sv
// Packet-atomic round-robin merge of NUM_CH client TX AXI-S streams onto one MAC TX stream.
// A channel is locked from its first beat until its tlast beat is accepted; every
// outgoing beat carries the source channel in m_tid.  tx_pause only blocks new grants.
module ofs_fim_hssi_tx_axis_arb #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int USER_W = 2,
    parameter int CH_W   = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    ofs_fim_hssi_tx_axis_arb_if.master         axis,
    input  logic                               tx_pause,
    output logic                               busy,
    output logic                               pkt_done
);
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CH_W-1:0]     r_sel;
    logic [CH_W-1:0]     r_last_grant;
    logic [CH_W-1:0]     w_grant_idx;
    logic                w_grant_valid;
    logic                w_grant;
    logic                w_accept;
    logic                w_out_free;
    logic                w_busy;
    logic [NUM_CH-1:0]   w_s_tready;

    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;
    logic                w_sel_last;
    logic [USER_W-1:0]   w_sel_user;

    logic                r_m_tvalid;
    logic [DATA_W-1:0]   r_m_tdata;
    logic [KEEP_W-1:0]   r_m_tkeep;
    logic                r_m_tlast;
    logic [USER_W-1:0]   r_m_tuser;
    logic [CH_W-1:0]     r_m_tid;
    logic                r_pkt_done;

    // The output slot can take a beat when empty or when its current beat leaves this cycle.
    assign w_out_free = ~r_m_tvalid | axis.m_tready;
    assign w_grant    = (r_state == IDLE) && !tx_pause && w_grant_valid;

    // Round-robin search: first requesting channel after the last granted one, with wrap.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_grant_valid && (c == ((int'(r_last_grant) + i) % NUM_CH)) && axis.s_tvalid[c]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = CH_W'(c);
                end
            end
        end
    end

    // Route the locked channel's beat towards the output register.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        w_sel_user  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_sel == CH_W'(c)) begin
                w_sel_valid = axis.s_tvalid[c];
                w_sel_data  = axis.s_tdata[c*DATA_W +: DATA_W];
                w_sel_keep  = axis.s_tkeep[c*KEEP_W +: KEEP_W];
                w_sel_last  = axis.s_tlast[c];
                w_sel_user  = axis.s_tuser[c*USER_W +: USER_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: lock on a grant, release once the tlast beat is taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_grant) w_next_state = LOCK;
            LOCK: if (w_accept && w_sel_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State outputs: only the locked channel sees tready, which follows MAC-side space combinationally.
    always_comb begin
        w_s_tready = '0;
        w_accept   = 1'b0;
        w_busy     = 1'b0;
        if (r_state == LOCK) begin
            w_busy = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                w_s_tready[c] = (r_sel == CH_W'(c)) & w_out_free;
            end
            w_accept = w_sel_valid & w_out_free;
        end
    end

    // Grant bookkeeping: latch the winner, and remember it as last_grant when its packet ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            if (w_grant) begin
                r_sel <= w_grant_idx;
            end
            if (w_accept && w_sel_last) begin
                r_last_grant <= r_sel;
            end
        end
    end

    // Output register: load on accept, empty when the MAC takes the beat and nothing replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
            r_m_tid    <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= w_accept & w_sel_last;
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_sel_data;
                r_m_tkeep  <= w_sel_keep;
                r_m_tlast  <= w_sel_last;
                r_m_tuser  <= w_sel_user;
                r_m_tid    <= r_sel;
            end else if (axis.m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign axis.s_tready = w_s_tready;
    assign axis.m_tvalid = r_m_tvalid;
    assign axis.m_tdata  = r_m_tdata;
    assign axis.m_tkeep  = r_m_tkeep;
    assign axis.m_tlast  = r_m_tlast;
    assign axis.m_tuser  = r_m_tuser;
    assign axis.m_tid    = r_m_tid;
    assign busy          = w_busy;
    assign pkt_done      = r_pkt_done;
endmodule
